nios_fprint_scratchpad_arbiter: RTL

NIOS_FPRINT_SCRATCHPAD_ARBITER -- requirements
Module: nios_fprint_scratchpad_arbiter

---
 rtl/nios_fprint_scratchpad_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/nios_fprint_scratchpad_arbiter.sv
// nios_fprint_scratchpad_arbiter
// -----------------------------------------------------------------------------
// Two-master Avalon-MM arbiter in front of a single-port on-chip scratchpad.
// Master 0 is the Nios CPU and master 1 is the fingerprint DMA.
//
// Arbitration is combinational. A requesting master is granted in the same
// cycle. When both masters request, the master that was not granted last wins.
// A continuously requesting master therefore waits at most one cycle.
//
// The scratchpad returns read data one cycle after the access. A small tag
// register sends that data back to whichever master issued the read.
//
// Ports:
//   clk, reset          sole clock; synchronous active-high reset
//   clken               global clock enable, forwarded to the memory;
//                       no grant is issued while it is low
//   mN_address/_byteenable/_read/_write/_writedata
//                       Avalon-MM request from master N (N = 0, 1)
//   mN_waitrequest      high while master N requests and is not granted
//   mN_readdata/_readdatavalid
//                       read response to master N; data is zero when not valid
//   mem_*               scratchpad port; mem_readdata is valid one cycle after
//                       a chipselected read
// -----------------------------------------------------------------------------
module nios_fprint_scratchpad_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clken,
  // master 0 (CPU)
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  // master 1 (fingerprint DMA)
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  // scratchpad port
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  logic req0, req1;
  logic can_grant;
  logic grant0, grant1;
  logic rd_grant;    // the current grant is a read that expects a response
  logic last_grant;  // index of the most recently granted master
  logic rd_pend;     // a read response is due in this cycle
  logic rd_tag;      // master that owns the pending response

  assign req0      = m0_read | m0_write;
  assign req1      = m1_read | m1_write;
  assign can_grant = clken & ~reset;

  // A master wins when it is alone, or when it was not the last one granted.
  assign grant0 = can_grant & req0 & (~req1 | last_grant);
  assign grant1 = can_grant & req1 & (~req0 | ~last_grant);

  assign m0_waitrequest = req0 & ~grant0;
  assign m1_waitrequest = req1 & ~grant1;

  assign mem_clken = clken;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    rd_grant       = 1'b0;
    if (grant0) begin
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_writedata  = m0_writedata;
      mem_chipselect = 1'b1;
      mem_write      = m0_write;
      // read together with write is treated as a write only
      rd_grant       = m0_read & ~m0_write;
    end else if (grant1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      mem_chipselect = 1'b1;
      mem_write      = m1_write;
      rd_grant       = m1_read & ~m1_write;
    end
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // the values from before the clock edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;  // master 0 wins the first contention after reset
      rd_pend    <= 1'b0;
      rd_tag     <= 1'b0;
    end else begin
      if (grant0 | grant1) last_grant <= grant1;
      rd_pend <= rd_grant;
      if (rd_grant) rd_tag <= grant1;
    end
  end

  // The response is gated by reset. A reset that arrives in the response
  // cycle therefore drops the pulse, not only the following state.
  assign m0_readdatavalid = rd_pend & ~rd_tag & ~reset;
  assign m1_readdatavalid = rd_pend &  rd_tag & ~reset;

  assign m0_readdata = m0_readdatavalid ? mem_readdata : '0;
  assign m1_readdata = m1_readdatavalid ? mem_readdata : '0;

endmodule
